// File: rtl/cc_deserializer.sv
// Line assembler: takes a start-offset descriptor, gathers BEATS wrap-ordered read beats
// into their natural word slots, then pushes {offset, pad, line} into the fill FIFO.
module cc_deserializer #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 8,
    parameter int OFS_W  = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_i,
    input  logic [OFS_W-1:0]                  req_offset_i,
    output logic                              req_ready_o,
    input  logic [DATA_W-1:0]                 rdata_i,
    input  logic                              rlast_i,
    input  logic                              rvalid_i,
    output logic                              rready_o,
    input  logic                              fifo_full_i,
    output logic                              fifo_wren_o,
    output logic [2*OFS_W+DATA_W*BEATS-1:0]   fifo_wdata_o,
    output logic                              err_o
);

    localparam int LINE_W  = DATA_W * BEATS;
    localparam int ENTRY_W = 2 * OFS_W + LINE_W;
    localparam logic [OFS_W-1:0] LAST_CNT = OFS_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_PUSH
    } state_e;

    state_e                        state_q, state_d;
    logic [OFS_W-1:0]              count_q, count_d;
    logic [OFS_W-1:0]              offset_q, offset_d;
    logic [BEATS-1:0][DATA_W-1:0]  line_q, line_d;
    logic                          err_q, err_d;

    // Slot index wraps naturally in OFS_W bits since BEATS is a power of two.
    function automatic logic [OFS_W-1:0] wrap_slot(input logic [OFS_W-1:0] base,
                                                   input logic [OFS_W-1:0] idx);
        return base + idx;
    endfunction

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        offset_d    = offset_q;
        line_d      = line_q;
        err_d       = 1'b0;
        req_ready_o = 1'b0;
        rready_o    = 1'b0;
        fifo_wren_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    offset_d = req_offset_i;
                    count_d  = '0;
                    state_d  = S_COLLECT;
                end
            end

            S_COLLECT: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    line_d[wrap_slot(offset_q, count_q)] = rdata_i;
                    count_d = count_q + OFS_W'(1);
                    // A full line is pushed even without rlast; a short burst is dropped.
                    if (count_q == LAST_CNT) begin
                        state_d = S_PUSH;
                        err_d   = !rlast_i;
                    end else if (rlast_i) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end

            S_PUSH: begin
                fifo_wren_o = !fifo_full_i;
                if (!fifo_full_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            offset_q <= '0;
            line_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            line_q   <= line_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;

    // Word 0 sits in the most significant DATA_W bits of the line field.
    always_comb begin
        fifo_wdata_o = {offset_q, {OFS_W{1'b0}}, {LINE_W{1'b0}}};
        for (int k = 0; k < BEATS; k++) begin
            fifo_wdata_o[DATA_W*(BEATS-k)-1 -: DATA_W] = line_q[k];
        end
    end

    logic unused_width_ok;
    assign unused_width_ok = (ENTRY_W == $bits(fifo_wdata_o));

endmodule

// File: tb/tb_cc_deserializer.sv
// Directed + randomized bench for cc_deserializer with a slot-placement reference model.
module tb_cc_deserializer;

    localparam int DATA_W  = 64;
    localparam int BEATS   = 8;
    localparam int OFS_W   = 3;
    localparam int LINE_W  = DATA_W * BEATS;
    localparam int ENTRY_W = 2 * OFS_W + LINE_W;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic [OFS_W-1:0]    req_offset;
    logic                req_ready;
    logic [DATA_W-1:0]   rdata;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic                fifo_full;
    logic                fifo_wren;
    logic [ENTRY_W-1:0]  fifo_wdata;
    logic                err;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0]   bd [BEATS];
    logic [ENTRY_W-1:0]  last_exp;

    cc_deserializer #(.DATA_W(DATA_W), .BEATS(BEATS), .OFS_W(OFS_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_offset_i (req_offset),
        .req_ready_o  (req_ready),
        .rdata_i      (rdata),
        .rlast_i      (rlast),
        .rvalid_i     (rvalid),
        .rready_o     (rready),
        .fifo_full_i  (fifo_full),
        .fifo_wren_o  (fifo_wren),
        .fifo_wdata_o (fifo_wdata),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: beat i of a burst starting at word off lands in word (off+i) mod BEATS;
    // word w occupies bits [DATA_W*(BEATS-w)-1 -: DATA_W], offset in the top OFS_W bits.
    function automatic logic [ENTRY_W-1:0] model_entry(input int off);
        logic [ENTRY_W-1:0] e;
        int slot;
        e = '0;
        e[ENTRY_W-1 -: OFS_W] = OFS_W'(off);
        for (int i = 0; i < BEATS; i++) begin
            slot = (off + i) % BEATS;
            e[DATA_W*(BEATS-slot)-1 -: DATA_W] = bd[i];
        end
        return e;
    endfunction

    // rlast_at: beat index carrying rlast (-1 = never). gaps: idle cycle before each beat.
    task automatic run_burst(input int off, input int rlast_at, input bit gaps, input int full_cyc);
        bit early;
        bit errx;
        int nb;
        early = (rlast_at >= 0) && (rlast_at < BEATS - 1);
        errx  = (rlast_at != BEATS - 1);
        nb    = early ? rlast_at + 1 : BEATS;

        @(negedge clk);
        req_valid  = 1'b1;
        req_offset = OFS_W'(off);
        #1;
        chk1("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;

        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                rvalid     = 1'b0;
                rlast      = 1'b1;
                rdata      = {$urandom, $urandom};
                req_valid  = 1'b1;
                req_offset = OFS_W'(off + 3);
                #1;
                chk1("rready_gap", rready, 1'b1);
                chk1("req_ready_busy", req_ready, 1'b0);
                chk1("wren_gap", fifo_wren, 1'b0);
                @(negedge clk);
                req_valid = 1'b0;
            end
            bd[i]  = {$urandom, $urandom};
            rvalid = 1'b1;
            rdata  = bd[i];
            rlast  = (i == rlast_at);
            #1;
            chk1("rready_collect", rready, 1'b1);
            @(negedge clk);
        end

        rvalid    = 1'b0;
        rlast     = 1'b0;
        rdata     = {$urandom, $urandom};
        fifo_full = (full_cyc > 0);
        #1;
        chk1("err_pulse", err, errx);

        if (early) begin
            chk1("wren_drop", fifo_wren, 1'b0);
            chk1("req_ready_after_err", req_ready, 1'b1);
            chk1("rready_after_err", rready, 1'b0);
            @(negedge clk);
            #1;
            chk1("err_one_cycle", err, 1'b0);
            chk1("wren_drop2", fifo_wren, 1'b0);
            return;
        end

        last_exp = model_entry(off);
        for (int c = 0; c < full_cyc; c++) begin
            chk1("wren_full", fifo_wren, 1'b0);
            chk1("rready_push", rready, 1'b0);
            chkw("wdata_stall", fifo_wdata, last_exp);
            @(negedge clk);
            if (c == full_cyc - 1) fifo_full = 1'b0;
            #1;
        end
        chk1("wren_push", fifo_wren, 1'b1);
        chkw("wdata_push", fifo_wdata, last_exp);
        chk1("req_ready_push", req_ready, 1'b0);
        @(negedge clk);
        #1;
        chk1("wren_once", fifo_wren, 1'b0);
        chk1("req_ready_back", req_ready, 1'b1);
        chk1("err_clear", err, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_offset  = '0;
        rdata       = '0;
        rlast       = 1'b0;
        rvalid      = 1'b0;
        fifo_full   = 1'b0;
        last_exp    = '0;

        #2;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_wren", fifo_wren, 1'b0);
        chk1("rst_err", err, 1'b0);
        chkw("rst_wdata", fifo_wdata, '0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Beats offered while idle must be refused.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rvalid = 1'b1;
            rlast  = 1'b1;
            rdata  = {$urandom, $urandom};
            #1;
            chk1("rready_idle", rready, 1'b0);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(negedge clk);
        #1;
        chk1("err_idle_beats", err, 1'b0);

        // Offset 0, clean burst.
        run_burst(0, BEATS - 1, 1'b0, 0);
        chkw("t1_word0", {{(ENTRY_W-DATA_W){1'b0}}, fifo_wdata[511:448]}, {{(ENTRY_W-DATA_W){1'b0}}, bd[0]});

        // Offset 5: word 0 holds beat 3.
        run_burst(5, BEATS - 1, 1'b0, 0);
        chkw("t2_offset", {{(ENTRY_W-OFS_W){1'b0}}, fifo_wdata[517:515]}, {{(ENTRY_W-OFS_W){1'b0}}, 3'd5});
        chkw("t2_word0", {{(ENTRY_W-DATA_W){1'b0}}, fifo_wdata[511:448]}, {{(ENTRY_W-DATA_W){1'b0}}, bd[3]});

        // Offset 2 with a bubble before every beat.
        run_burst(2, BEATS - 1, 1'b1, 0);

        // FIFO full for 10 cycles after the last beat.
        run_burst(6, BEATS - 1, 1'b0, 10);

        // Early rlast on the 4th beat, then a clean burst.
        run_burst(1, 3, 1'b0, 0);
        run_burst(7, BEATS - 1, 1'b0, 0);

        // Missing rlast on the 8th beat: error pulse but line still pushed.
        run_burst(3, -1, 1'b0, 2);

        // Reset after three beats.
        @(negedge clk);
        req_valid  = 1'b1;
        req_offset = 3'd4;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1;
            rdata  = {$urandom, $urandom};
            rlast  = 1'b0;
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_rready", rready, 1'b0);
        chk1("rst_mid_wren", fifo_wren, 1'b0);
        chk1("rst_mid_req_ready", req_ready, 1'b1);
        chkw("rst_mid_wdata", fifo_wdata, '0);
        @(negedge clk);
        #1;
        chk1("rst_hold_wren", fifo_wren, 1'b0);
        rvalid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk1("rst_after_wren", fifo_wren, 1'b0);
        chk1("rst_after_err", err, 1'b0);
        run_burst(4, BEATS - 1, 1'b0, 0);

        // Randomized bursts.
        for (int n = 0; n < 12; n++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            run_burst(int'($urandom_range(0, BEATS - 1)),
                      (sel == 0) ? int'($urandom_range(0, BEATS - 2)) : ((sel == 1) ? -1 : BEATS - 1),
                      1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
